// File: rtl/serial_adder_ctrl.sv
// -----------------------------------------------------------------------------
// serial_adder_ctrl
//   Bit-serial addition sequencer. A request captures two WIDTH-bit operands
//   and a carry-in. One full-adder cell is then used for WIDTH cycles, LSB
//   first, with the carry held in a register between bits. The result is
//   registered at completion and held until the next completion.
//
//   Optional feature: define SERIAL_ADD_OVF_EN to add the signed-overflow
//   output ovf. With the macro undefined, the port and its logic are absent.
//
// Ports
//   clk    in   1      rising-edge clock
//   rst_n  in   1      asynchronous active-low reset
//   start  in   1      request; sampled only while idle
//   a, b   in   WIDTH  operands, captured when start is accepted
//   cin    in   1      carry-in, captured when start is accepted
//   busy   out  1      addition in progress
//   done   out  1      one-cycle completion pulse
//   sum    out  WIDTH  registered result
//   cout   out  1      registered carry-out
//   ovf    out  1      registered signed overflow (SERIAL_ADD_OVF_EN only)
// -----------------------------------------------------------------------------
module serial_adder_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SERIAL_ADD_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_sh_q, a_sh_d;
  logic [WIDTH-1:0]   b_sh_q, b_sh_d;
  logic [WIDTH-1:0]   s_sh_q, s_sh_d;
  logic               carry_q, carry_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic               cout_q, cout_d;
`ifdef SERIAL_ADD_OVF_EN
  logic               ovf_q, ovf_d;
`endif

  logic               accept_c;
  logic               last_c;
  logic               cell_sum_c;
  logic               cell_cout_c;
  logic [WIDTH-1:0]   s_shift_c;

  // Shared single-bit full-adder cell and the shifted partial sum it feeds.
  always_comb begin
    cell_sum_c  = a_sh_q[0] ^ b_sh_q[0] ^ carry_q;
    cell_cout_c = (a_sh_q[0] & b_sh_q[0]) | (a_sh_q[0] & carry_q) | (b_sh_q[0] & carry_q);
    s_shift_c   = {cell_sum_c, s_sh_q[WIDTH-1:1]};
    accept_c    = (state_q == S_IDLE) && start;
    last_c      = (state_q == S_RUN) && (cnt_q == LAST_BIT);
  end

  // State register and all datapath/output flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      s_sh_q  <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      s_sh_q  <= s_sh_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
`ifdef SERIAL_ADD_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (start)  state_d = S_RUN;
      S_RUN:   if (last_c) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath and registered-output next values.
  always_comb begin
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    s_sh_d  = s_sh_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    sum_d   = sum_q;
    cout_d  = cout_q;
`ifdef SERIAL_ADD_OVF_EN
    ovf_d   = ovf_q;
`endif

    if (accept_c) begin
      a_sh_d  = a;
      b_sh_d  = b;
      s_sh_d  = '0;
      carry_d = cin;
      cnt_d   = '0;
      busy_d  = 1'b1;
    end

    if (state_q == S_RUN) begin
      a_sh_d  = {1'b0, a_sh_q[WIDTH-1:1]};
      b_sh_d  = {1'b0, b_sh_q[WIDTH-1:1]};
      s_sh_d  = s_shift_c;
      carry_d = cell_cout_c;
      cnt_d   = cnt_q + CNT_W'(1);
      if (last_c) begin
        sum_d  = s_shift_c;
        cout_d = cell_cout_c;
        done_d = 1'b1;
        busy_d = 1'b0;
`ifdef SERIAL_ADD_OVF_EN
        // carry_q here is the carry into the MSB; cell_cout_c is the carry out.
        ovf_d  = carry_q ^ cell_cout_c;
`endif
      end
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;
`ifdef SERIAL_ADD_OVF_EN
  assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// -----------------------------------------------------------------------------
// tb_serial_adder_ctrl
//   Directed bench for serial_adder_ctrl (WIDTH=8). Expected results are
//   hand-computed constants. Summary line: CHECKS <n> ERRORS <n>.
//   Honours SERIAL_ADD_OVF_EN to connect and check ovf.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_serial_adder_ctrl;

  localparam int unsigned WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
`ifdef SERIAL_ADD_OVF_EN
  logic             ovf;
`endif

  int               checks = 0;
  int               errors = 0;
  logic [WIDTH-1:0] prev_sum;

  serial_adder_ctrl #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
`ifdef SERIAL_ADD_OVF_EN
    ,
    .ovf   (ovf)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0;
    a     = '0;
    b     = '0;
    cin   = 1'b0;
    #3;
    checks++;
    if ({busy, done, sum, cout} !== {1'b0, 1'b0, 8'h00, 1'b0}) begin
      errors++;
      $display("FAIL reset_outputs: busy=%b done=%b sum=%h cout=%b, want 0 0 00 0", busy, done, sum, cout);
    end
`ifdef SERIAL_ADD_OVF_EN
    checks++;
    if (ovf !== 1'b0) begin
      errors++;
      $display("FAIL reset_ovf: got %b want 0", ovf);
    end
`endif
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    checks++;
    if ({busy, done} !== 2'b00) begin
      errors++;
      $display("FAIL reset_idle: busy=%b done=%b want 0 0", busy, done);
    end
    prev_sum = 8'h00;
  endtask

  // One full addition with cycle-by-cycle checks of busy/done/sum hold.
  task automatic test_add(input string name, input logic [7:0] ta, input logic [7:0] tb_op,
                          input logic tc, input logic [7:0] es, input logic ec, input logic eo);
    int busy_cnt;
    a     = ta;
    b     = tb_op;
    cin   = tc;
    start = 1'b1;
    tick();
    start = 1'b0;
    a     = ~ta;
    b     = ~tb_op;
    cin   = ~tc;
    busy_cnt = busy ? 1 : 0;
    for (int i = 1; i <= 8; i++) begin
      tick();
      if (i < 8) begin
        busy_cnt += busy ? 1 : 0;
        checks++;
        if (done !== 1'b0 || sum !== prev_sum) begin
          errors++;
          $display("FAIL %s_run%0d: done=%b sum=%h want done=0 sum=%h", name, i, done, sum, prev_sum);
        end
      end else begin
        checks++;
        if ({done, busy} !== 2'b10) begin
          errors++;
          $display("FAIL %s_done: done=%b busy=%b want 1 0", name, done, busy);
        end
        checks++;
        if (sum !== es || cout !== ec) begin
          errors++;
          $display("FAIL %s_result: sum=%h cout=%b want sum=%h cout=%b (ovf %b)", name, sum, cout, es, ec, eo);
        end
`ifdef SERIAL_ADD_OVF_EN
        checks++;
        if (ovf !== eo) begin
          errors++;
          $display("FAIL %s_ovf: got %b want %b", name, ovf, eo);
        end
`endif
      end
    end
    checks++;
    if (busy_cnt != 8) begin
      errors++;
      $display("FAIL %s_busy_len: got %0d cycles want 8", name, busy_cnt);
    end
    tick();
    checks++;
    if (done !== 1'b0 || sum !== es) begin
      errors++;
      $display("FAIL %s_after: done=%b sum=%h want done=0 sum=%h", name, done, sum, es);
    end
    a        = '0;
    b        = '0;
    cin      = 1'b0;
    prev_sum = es;
  endtask

  // A start pulse during RUN must not disturb the operation in flight.
  task automatic test_ignore_busy();
    int done_cnt;
    done_cnt = 0;
    a     = 8'h10;
    b     = 8'h20;
    cin   = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    a     = 8'hAA;
    b     = 8'h55;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (done) begin
        done_cnt++;
        checks++;
        if (sum !== 8'h30 || cout !== 1'b0) begin
          errors++;
          $display("FAIL ignore_result: sum=%h cout=%b want 30 0", sum, cout);
        end
      end else if (busy) begin
        checks++;
        if (sum !== prev_sum) begin
          errors++;
          $display("FAIL ignore_hold: sum=%h want %h", sum, prev_sum);
        end
      end
    end
    checks++;
    if (done_cnt != 1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL ignore_count: done pulses=%0d busy=%b want 1 0", done_cnt, busy);
    end
    a        = '0;
    b        = '0;
    prev_sum = 8'h30;
  endtask

  // start held high: results every WIDTH+1 cycles.
  task automatic test_back_to_back();
    int done_cyc[$];
    a     = 8'h03;
    b     = 8'h04;
    cin   = 1'b0;
    start = 1'b1;
    tick();
    for (int i = 1; i <= 30; i++) begin
      tick();
      if (done) begin
        done_cyc.push_back(i);
        checks++;
        if (sum !== 8'h07) begin
          errors++;
          $display("FAIL b2b_result: sum=%h want 07", sum);
        end
      end
    end
    checks++;
    if (done_cyc.size() != 3) begin
      errors++;
      $display("FAIL b2b_count: got %0d pulses want 3", done_cyc.size());
    end else begin
      checks++;
      if (done_cyc[0] != 8 || done_cyc[1] != 17 || done_cyc[2] != 26) begin
        errors++;
        $display("FAIL b2b_spacing: pulses at %0d %0d %0d want 8 17 26", done_cyc[0], done_cyc[1], done_cyc[2]);
      end
    end
    start = 1'b0;
    for (int i = 0; i < 12; i++) tick();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL b2b_drain: busy=%b want 0", busy);
    end
    a        = '0;
    b        = '0;
    prev_sum = 8'h07;
  endtask

  // Asynchronous reset during RUN aborts with no completion.
  task automatic test_reset_mid_run();
    int done_cnt;
    done_cnt = 0;
    a     = 8'h35;
    b     = 8'h4A;
    cin   = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, sum, cout} !== {1'b0, 1'b0, 8'h00, 1'b0}) begin
      errors++;
      $display("FAIL midrun_reset: busy=%b done=%b sum=%h cout=%b want 0 0 00 0", busy, done, sum, cout);
    end
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done) done_cnt++;
    end
    checks++;
    if (done_cnt != 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL midrun_no_done: pulses=%0d busy=%b want 0 0", done_cnt, busy);
    end
    a        = '0;
    b        = '0;
    prev_sum = 8'h00;
  endtask

  initial begin
    test_reset();
    test_add("add_35_4a", 8'h35, 8'h4A, 1'b0, 8'h7F, 1'b0, 1'b0);
    test_add("add_ff_01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
    test_add("add_7f_01", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
    test_add("add_ff_ff_c", 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0);
    test_add("add_80_80", 8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1);
    test_add("add_00_00_c", 8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0);
    test_ignore_busy();
    test_back_to_back();
    test_reset_mid_run();
    test_add("post_reset", 8'h01, 8'h02, 1'b0, 8'h03, 1'b0, 1'b0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_adder_ctrl.md
# serial_adder_ctrl

Bit-serial addition sequencer: accepts two WIDTH-bit operands and a carry-in, then drives one single-bit combinational full-adder cell for WIDTH consecutive cycles, LSB first, with the carry registered between bits. It trades WIDTH cycles of latency for one adder cell. It sits between a requester using a start/busy/done handshake and the shared full-adder datapath.

## Interface
- WIDTH, 8: operand/result width in bits; legal range WIDTH ≥ 2
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only when idle
- a  input  WIDTH  operand A, captured on accepted start
- b  input  WIDTH  operand B, captured on accepted start
- cin  input  1  carry-in, captured on accepted start
- busy  output  1  high while an addition is in progress
- done  output  1  single-cycle completion pulse
- sum  output  WIDTH  registered result; holds until the next completion
- cout  output  1  registered carry-out; holds until the next completion
- ovf  output  1  signed overflow; present only with SERIAL_ADD_OVF_EN (see Configuration)

## Operation
- States:
  - IDLE: waiting for a request.
  - RUN: processing one bit per cycle.
- Internal registers:
  - a_sh, b_sh, s_sh: WIDTH-bit shift registers.
  - carry: 1 bit.
  - bit counter: $clog2(WIDTH) bits.
- IDLE with start=1 at an edge:
  - a_sh←a, b_sh←b, carry←cin, counter←0, s_sh←0.
  - Go to RUN; busy←1.
- RUN, every edge:
  - The cell sees (a_sh[0], b_sh[0], carry).
  - s_sh←{cell sum, s_sh[WIDTH-1:1]}.
  - a_sh and b_sh shift right by 1 (zero fill).
  - carry←cell carry-out.
  - counter←counter+1.
- RUN edge with counter==WIDTH-1 (last bit):
  - sum←final shifted s_sh value.
  - cout←cell carry-out.
  - done←1, busy←0.
  - Return to IDLE.
- done is forced to 0 on every edge where a completion does not occur.
- start while busy=1 is ignored; operands captured at acceptance are used unchanged.
- start during the done cycle is accepted, because the state is already IDLE.
- Arithmetic: {cout,sum} = a + b + cin modulo 2^(WIDTH+1); unsigned, no saturation.
- sum and cout do not change during RUN; they show the previous result until completion.

## Timing
- Reset (rst_n=0, asynchronous):
  - State←IDLE.
  - busy, done, sum, cout, ovf, and all internal registers ← 0.
- Reset takes effect immediately, independent of clk.
- Reset mid-RUN aborts the operation; no done pulse follows.
- Latency: start accepted at edge E0; bits 0..WIDTH-1 are processed at edges E1..EWIDTH.
  - done and the new sum/cout are visible after edge EWIDTH.
  - done is low again after EWIDTH+1 unless that edge completes another operation. This cannot happen, since the minimum operation length is WIDTH+1 edges.
- busy is high from after E0 through the cycle ending at EWIDTH.
- Throughput with start held high: one result per WIDTH+1 cycles.
- The cell path is combinational within one cycle: a_sh[0]/b_sh[0]/carry → cell → s_sh/carry D inputs.

## Configuration
- SERIAL_ADD_OVF_EN defined:
  - ovf port exists.
  - ovf is registered at completion as (carry into MSB) XOR (carry out of MSB), i.e. the carry register value entering the last bit XOR the final carry-out.
  - ovf holds with sum, and resets to 0.
- Not defined: no ovf port and no associated logic. All other behaviour is identical.

## Test plan
- WIDTH=8, a=8'h35, b=8'h4A, cin=0, start one cycle:
  - busy for 8 cycles.
  - done pulses once at the 8th edge after acceptance.
  - sum=8'h7F, cout=0, ovf=0.
- a=8'hFF, b=8'h01, cin=0 → sum=8'h00, cout=1, ovf=0.
- a=8'h7F, b=8'h01, cin=0 → sum=8'h80, cout=0, ovf=1.
- a=8'hFF, b=8'hFF, cin=1 → sum=8'hFF, cout=1, ovf=0.
- Start a=8'h10, b=8'h20, then pulse start with a=8'hAA, b=8'h55 three cycles later:
  - The second start is ignored.
  - Single done pulse with sum=8'h30.
  - sum holds its prior value throughout busy.
- Hold start=1 continuously with fixed operands:
  - done pulses every 9 cycles.
- Assert rst_n=0 on the 4th RUN cycle:
  - busy, done, sum, cout drop to 0 immediately.
  - No done follows.
  - A subsequent start of 8'h01+8'h02 yields sum=8'h03.
